burst_arbiter: RTL and testbench
================================

# burst_arbiter

Two-master burst arbiter that schedules which source writes into the shared path FIFO. Ownership alternates between master 1 and master 2 in fixed-length bursts. The block drives per-master stop lines, the data-mux select and the FIFO write enable, and it backpressures both masters when the FIFO is full. It sits between the two upstream masters and the path FIFO/data mux; the memory-side req/gnt logic is not part of this block.

## Interface
- `DWIDTH`, 8, data width of the shared path (used only by the package mux helper)
- `BURST_LEN`, 10, beats accepted per ownership window; legal range 2..15
- `CNT_W`, 4, beat counter width; must hold `BURST_LEN-1`
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `valid1_i` input 1: master 1 presents a beat
- `valid2_i` input 1: master 2 presents a beat
- `full_i` input 1: path FIFO full
- `stop1_o` output 1: master 1 must not expect acceptance
- `stop2_o` output 1: master 2 must not expect acceptance
- `sel_o` output 1: data-mux select; 0 = master 1, 1 = master 2
- `wr_en_o` output 1: FIFO write strobe for the selected master's beat
- `cnt_o` output CNT_W: beats accepted in the current window
- `burst_done_o` output 1: one-cycle pulse after a window completes

## Operation
- **State:** `owner` register with states S_M1 and S_M2, plus the beat counter `cnt`.
- **Reset values:** `owner` = S_M1, `cnt` = 0, `burst_done_o` = 0, `sel_o` = 0, `wr_en_o` = 0. With `full_i` = 0: `stop1_o` = 0, `stop2_o` = 1.
- **Stop lines (combinational):**
  - `stop1_o` = (owner != S_M1) | `full_i`
  - `stop2_o` = (owner != S_M2) | `full_i`
- **Select:** `sel_o` = owner.
- **Accept:** a beat is accepted when `wr_en_o` = valid_owner & !`full_i`. The non-owner's valid is ignored. A master may hold valid while stopped; this is legal.
- **Counting:**
  - On an accepted beat with `cnt` < `BURST_LEN-1`: `cnt` increments.
  - On an accepted beat with `cnt` = `BURST_LEN-1`: `cnt` goes to 0, `owner` toggles, and `burst_done_o` is 1 in the next cycle.
  - The toggle happens even if the other master is idle.
- **Full:** while `full_i` = 1, both stops are high, `wr_en_o` = 0, and `cnt` and `owner` are frozen.
- **No valid:** `cnt` and `owner` hold.
- **Reset mid-burst:** everything returns asynchronously to reset values. The partial count is discarded and master 1 owns the next window.

## Timing
- `wr_en_o`, `stop*_o` and `sel_o` have zero-cycle latency from `valid*_i`, `full_i` and the state.
- **Handover:** last beat accepted in cycle N.
  - In cycle N+1: new owner, the new owner's stop is low, `cnt` = 0, `burst_done_o` = 1.
  - No bubble cycle.
- **`full_i` rising in the same cycle as the last beat:** the beat is not accepted and the handover waits until `full_i` falls.
- The `cnt` width rule is checked by an elaboration-time assertion: `BURST_LEN-1` < 2**CNT_W.

## Configuration
- **Macro:** `BURST_ARBITER_PREEMPT_EN`.
- **Defined:**
  - Trigger: the owner's valid is 0, the other master's valid is 1 and `full_i` = 0 in cycle N.
  - Effect: owner toggles at the end of cycle N and `cnt` goes to 0. `burst_done_o` is not pulsed, because the window ended by preemption.
- **Undefined:** strict alternation by completed bursts only. An idle owner blocks the other master indefinitely.

## Structure
- **Shared package `burst_arb_pkg`:**
  - `owner_t` enum: S_M1 = 1'b0, S_M2 = 1'b1.
  - Default constants `BURST_LEN_DEF` = 10 and `CNT_W_DEF` = 4.
  - The path data-mux helper function, used by the datapath with `sel_o`.
- **Sub-modules:** none. The counter and the two-state FSM are small enough to stay in the top-level block.

## Test plan
- **Reset then master 1 burst:** release reset, hold `valid1_i` = 1 for 10 cycles. Expect `wr_en_o` = 1 for 10 cycles and `cnt_o` 0→9. In cycle 11: `sel_o` = 1, `stop1_o` = 1, `stop2_o` = 0, `burst_done_o` = 1 for exactly one cycle.
- **Non-owner valid ignored:** `valid2_i` = 1 with owner S_M1 and `valid1_i` = 0. Expect `wr_en_o` = 0 and `cnt_o` holds at 0. Without the macro, no switch ever occurs.
- **Full backpressure:** at `cnt_o` = 4, assert `full_i` for 3 cycles with valid high. Expect both stops = 1, `wr_en_o` = 0, `cnt_o` = 4 throughout. After `full_i` falls, counting resumes at 4→5.
- **Full on last beat:** at `cnt_o` = 9, `full_i` = 1 for 1 cycle. Expect no handover. The next cycle accepts the beat, then the owner switches.
- **Reset mid-burst:** pulse `rst_n` low at `cnt_o` = 6 with owner S_M2. Expect immediate `cnt_o` = 0, `sel_o` = 0, `stop2_o` = 1, `burst_done_o` = 0.
- **`BURST_ARBITER_PREEMPT_EN`:** owner S_M1 at `cnt_o` = 3, drop `valid1_i` with `valid2_i` = 1. Expect `sel_o` = 1 and `cnt_o` = 0 in the next cycle, and `burst_done_o` stays 0.

Source files
------------

// File: rtl/burst_arbiter_pkg.sv
// Shared types and constants for the two-master burst arbiter,
// plus the path data-mux helper driven by the arbiter's select.
package burst_arb_pkg;

   typedef enum logic {
      S_M1 = 1'b0,
      S_M2 = 1'b1
   } owner_t;

   localparam int BURST_LEN_DEF = 10;
   localparam int CNT_W_DEF     = 4;
   localparam int DWIDTH_DEF    = 8;

   function automatic logic [DWIDTH_DEF-1:0] path_mux(
      input owner_t                sel,
      input logic [DWIDTH_DEF-1:0] dat1,
      input logic [DWIDTH_DEF-1:0] dat2
   );
      return (sel == S_M2) ? dat2 : dat1;
   endfunction

endpackage

// File: rtl/burst_arbiter_if.sv
// Handshake bundle between the two upstream masters, the path FIFO and the arbiter.
// slave = arbiter side, master = environment side (masters + FIFO).
interface burst_arbiter_if
   import burst_arb_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             valid1_i;
   logic             valid2_i;
   logic             full_i;
   logic             stop1_o;
   logic             stop2_o;
   logic             sel_o;
   logic             wr_en_o;
   logic [CNT_W-1:0] cnt_o;
   logic             burst_done_o;

   modport slave (
      input  valid1_i, valid2_i, full_i,
      output stop1_o, stop2_o, sel_o, wr_en_o, cnt_o, burst_done_o
   );

   modport master (
      output valid1_i, valid2_i, full_i,
      input  stop1_o, stop2_o, sel_o, wr_en_o, cnt_o, burst_done_o
   );
endinterface

// File: rtl/burst_arbiter.sv
// Alternates FIFO write ownership between two masters in BURST_LEN-beat windows; stops/select/wr_en
// are combinational, full_i freezes everything. BURST_ARBITER_PREEMPT_EN lets an idle owner be preempted.
module burst_arbiter
   import burst_arb_pkg::*;
#(
   parameter int DWIDTH    = DWIDTH_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = CNT_W_DEF
)(
   input  logic           clk,
   input  logic           rst_n,
   burst_arbiter_if.slave arb_if
);

   if (BURST_LEN < 2 || BURST_LEN > 15) begin : g_bad_len
      $error("burst_arbiter: BURST_LEN outside 2..15");
   end
   if ((BURST_LEN - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
      $error("burst_arbiter: CNT_W cannot hold BURST_LEN-1");
   end
   if (DWIDTH < 1 || DWIDTH > DWIDTH_DEF) begin : g_bad_dwidth
      $error("burst_arbiter: DWIDTH exceeds the path_mux helper width");
   end

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   owner_t           r_owner;
   owner_t           w_owner_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_done;
   logic             w_done_nxt;

   logic             w_valid_own;
   logic             w_valid_oth;
   logic             w_accept;
   owner_t           w_owner_flip;

   assign w_valid_own  = (r_owner == S_M1) ? arb_if.valid1_i : arb_if.valid2_i;
   assign w_valid_oth  = (r_owner == S_M1) ? arb_if.valid2_i : arb_if.valid1_i;
   assign w_accept     = w_valid_own & ~arb_if.full_i;
   assign w_owner_flip = (r_owner == S_M1) ? S_M2 : S_M1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= S_M1;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      if (w_accept) begin
         if (r_cnt == LAST_BEAT) begin
            w_owner_nxt = w_owner_flip;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
         end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
         end
      end
`ifdef BURST_ARBITER_PREEMPT_EN
      // Preempted window ends without a burst_done pulse.
      else if (!w_valid_own && w_valid_oth && !arb_if.full_i) begin
         w_owner_nxt = w_owner_flip;
         w_cnt_nxt   = '0;
      end
`else
      else if (w_valid_oth) begin
         // An idle owner keeps the window; the other master just waits.
         w_owner_nxt = r_owner;
      end
`endif
   end

   always_comb begin
      arb_if.stop1_o      = (r_owner != S_M1) | arb_if.full_i;
      arb_if.stop2_o      = (r_owner != S_M2) | arb_if.full_i;
      arb_if.sel_o        = r_owner;
      arb_if.wr_en_o      = w_accept;
      arb_if.cnt_o        = r_cnt;
      arb_if.burst_done_o = r_done;
   end

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed vector table, hand sequences for reset/preempt, then random stimulus vs a beat-count model.
module tb_burst_arbiter;

   localparam int BLEN = 10;
   localparam int CW   = 4;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   burst_arbiter_if #(.CNT_W(CW)) arb_if ();

   burst_arbiter #(.DWIDTH(8), .BURST_LEN(BLEN), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          v1, v2, full;
      logic          wr, sel, s1, s2, done;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic v1, v2, full, wr, sel, s1, s2, done, input int cnt);
      vec_t v;
      v.v1 = v1; v.v2 = v2; v.full = full;
      v.wr = wr; v.sel = sel; v.s1 = s1; v.s2 = s2; v.done = done;
      v.cnt = CW'(cnt);
      tv.push_back(v);
   endfunction

   function automatic logic [15:0] pack_exp(input logic wr, sel, s1, s2, done, input int cnt);
      return {7'b0, wr, sel, s1, s2, done, CW'(cnt)};
   endfunction

   function automatic logic [15:0] dut_outs();
      return {7'b0, arb_if.wr_en_o, arb_if.sel_o, arb_if.stop1_o, arb_if.stop2_o,
              arb_if.burst_done_o, arb_if.cnt_o};
   endfunction

   // Field order in reported values: {wr_en, sel, stop1, stop2, burst_done, cnt[3:0]}
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %03h expected %03h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v1, v2, full);
      arb_if.valid1_i = v1;
      arb_if.valid2_i = v2;
      arb_if.full_i   = full;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: owner as master number, beats counted up to BLEN.
   int  m_owner;
   int  m_beats;
   bit  m_done;

   initial begin
      rst_n = 1'b1;
      drive(0, 0, 0);
      #2 rst_n = 1'b0;
      #1 check("reset_state", dut_outs(), pack_exp(0, 0, 0, 1, 0, 0));
      drive(1, 1, 1);
      #1 check("reset_full", dut_outs(), pack_exp(0, 0, 1, 1, 0, 0));
      @(negedge clk);
      drive(0, 0, 0);
      rst_n = 1'b1;

      // Master 1 full burst, handover, master 2 partial burst with full stalls.
      for (int k = 0; k < BLEN; k++) add(1, 0, 0, 1, 0, 0, 1, 0, k);
      add(0, 0, 0, 0, 1, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(0, 1, 0, 1, 1, 1, 0, 0, k);
      for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 1, 1, 1, 0, 4);
      for (int k = 4; k < 9; k++) add(0, 1, 0, 1, 1, 1, 0, 0, k);
      add(0, 1, 1, 0, 1, 1, 1, 0, 9);
      add(0, 1, 0, 1, 1, 1, 0, 0, 9);
      add(1, 0, 0, 1, 0, 0, 1, 1, 0);
`ifdef BURST_ARBITER_PREEMPT_EN
      add(0, 1, 0, 0, 0, 0, 1, 0, 1);
      add(0, 1, 0, 1, 1, 1, 0, 0, 0);
`else
      for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1);
`endif

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         drive(tv[i].v1, tv[i].v2, tv[i].full);
         #1 check($sformatf("vec%0d", i), dut_outs(),
                  pack_exp(tv[i].wr, tv[i].sel, tv[i].s1, tv[i].s2, tv[i].done, int'(tv[i].cnt)));
      end

      // Asynchronous reset with master 2 owning at cnt 6.
      do_reset();
      for (int k = 0; k < BLEN; k++) begin @(negedge clk); drive(1, 0, 0); end
      for (int k = 0; k < 6; k++) begin @(negedge clk); drive(0, 1, 0); end
      @(negedge clk);
      drive(0, 1, 0);
      #1 check("pre_reset", dut_outs(), pack_exp(1, 1, 1, 0, 0, 6));
      #1 rst_n = 1'b0;
      #1 check("mid_reset", dut_outs(), pack_exp(0, 0, 0, 1, 0, 0));
      @(negedge clk);
      drive(0, 0, 0);
      rst_n = 1'b1;

`ifdef BURST_ARBITER_PREEMPT_EN
      do_reset();
      for (int k = 0; k < 3; k++) begin @(negedge clk); drive(1, 0, 0); end
      @(negedge clk);
      drive(0, 1, 0);
      #1 check("preempt_trig", dut_outs(), pack_exp(0, 0, 0, 1, 0, 3));
      @(negedge clk);
      #1 check("preempt_after", dut_outs(), pack_exp(1, 1, 1, 0, 0, 0));
`endif

      // Random phase.
      do_reset();
      m_owner = 1;
      m_beats = 0;
      m_done  = 0;
      for (int c = 0; c < 3000; c++) begin
         logic v1, v2, full, vo, vx, acc;
         @(negedge clk);
         v1   = ($urandom_range(0, 3) != 0);
         v2   = ($urandom_range(0, 2) != 0);
         full = ($urandom_range(0, 4) == 0);
         drive(v1, v2, full);
         vo  = (m_owner == 1) ? v1 : v2;
         vx  = (m_owner == 1) ? v2 : v1;
         acc = vo && !full;
         #1 check($sformatf("rand%0d", c), dut_outs(),
                  pack_exp(acc, m_owner == 2, (m_owner != 1) || full, (m_owner != 2) || full,
                           m_done, m_beats));
         m_done = 0;
         if (acc) begin
            m_beats++;
            if (m_beats == BLEN) begin
               m_beats = 0;
               m_owner = 3 - m_owner;
               m_done  = 1;
            end
         end
`ifdef BURST_ARBITER_PREEMPT_EN
         else if (!vo && vx && !full) begin
            m_beats = 0;
            m_owner = 3 - m_owner;
         end
`else
         else if (vx) m_beats = m_beats;
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
